// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// State encoding is fixed so that debug traces stay comparable.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle with the start/busy/done handshake.
// master drives operands; slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  diff,
    input  borrow_out
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output diff,
    output borrow_out
  );

endinterface

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor cell: D = A - B - Bin.
// Purely combinational; reused unchanged by the serial datapath.
module full_sub (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Result and final borrow are registered on entry to DONE.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_a_q, sr_a_d;
  logic [WIDTH-1:0] sr_b_q, sr_b_d;
  logic [WIDTH-1:0] sr_d_q, sr_d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             fs_d;
  logic             fs_bout;

  full_sub u_fs (
    .A    (sr_a_q[0]),
    .B    (sr_b_q[0]),
    .Bin  (borrow_q),
    .D    (fs_d),
    .Bout (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    sr_a_d   = sr_a_q;
    sr_b_d   = sr_b_q;
    sr_d_d   = sr_d_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bo_d     = bo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_a_d   = bus.a;
          sr_b_d   = bus.b;
          sr_d_d   = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        sr_a_d   = sr_a_q >> 1;
        sr_b_d   = sr_b_q >> 1;
        sr_d_d   = {fs_d, sr_d_q[WIDTH-1:1]};
        borrow_d = fs_bout;
        // Last bit lands in sr_d on this edge, so capture the shifted value.
        if (cnt_q == LAST) begin
          diff_d  = {fs_d, sr_d_q[WIDTH-1:1]};
          bo_d    = fs_bout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_a_q   <= '0;
      sr_b_q   <= '0;
      sr_d_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_a_q   <= sr_a_d;
      sr_b_q   <= sr_b_d;
      sr_d_q   <= sr_d_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bo_q     <= bo_d;
    end
  end

  always_comb begin
    bus.busy       = (state_q == LOAD) || (state_q == SHIFT);
    bus.done       = (state_q == DONE);
    bus.diff       = diff_q;
    bus.borrow_out = bo_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed, random, handshake, reset and
// exhaustive 4-bit checks against plain arithmetic.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor_if #(.WIDTH(8)) b8 ();
  serial_subtractor_if #(.WIDTH(4)) b4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input bit noise);
    logic [7:0] old_diff;
    logic       old_bo;
    logic [7:0] exp_d;
    logic       exp_bo;
    int         edges;
    bit         seen;
    bit         stable;
    exp_d    = 8'(a - b);
    exp_bo   = (a < b);
    old_diff = b8.diff;
    old_bo   = b8.borrow_out;
    b8.a     = a;
    b8.b     = b;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    edges    = 1;
    seen     = 1'b0;
    stable   = 1'b1;
    chk("busy_load", b8.busy, 1);
    while (!seen && edges < 20) begin
      if (noise && edges < 8) b8.start = 1'($urandom_range(0, 1));
      else b8.start = 1'b0;
      b8.a = 8'($urandom);
      b8.b = 8'($urandom);
      @(posedge clk); #1;
      edges++;
      if (b8.done) seen = 1'b1;
      else if (b8.diff !== old_diff || b8.borrow_out !== old_bo)
        stable = 1'b0;
    end
    b8.start = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", edges, 10);
    chk("diff", b8.diff, exp_d);
    chk("borrow", b8.borrow_out, exp_bo);
    chk("hold_busy", stable, 1);
    @(posedge clk); #1;
    chk("done_pulse", b8.done, 0);
    chk("idle_busy", b8.busy, 0);
    chk("diff_held", b8.diff, exp_d);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    int edges;
    bit seen;
    b4.a     = a;
    b4.b     = b;
    b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    edges    = 1;
    seen     = 1'b0;
    while (!seen && edges < 12) begin
      @(posedge clk); #1;
      edges++;
      if (b4.done) seen = 1'b1;
    end
    chk("w4_done", seen, 1);
    chk("w4_diff", b4.diff, 4'((a - b) & 4'hF));
    chk("w4_borrow", b4.borrow_out, (a < b));
    @(posedge clk); #1;
  endtask

  initial begin
    int dones;
    int last_done;
    int gap_bad;
    bit seen;
    b8.start = 1'b0;
    b8.a     = '0;
    b8.b     = '0;
    b4.start = 1'b0;
    b4.a     = '0;
    b4.b     = '0;
    #2;
    chk("rst_busy", b8.busy, 0);
    chk("rst_done", b8.done, 0);
    chk("rst_diff", b8.diff, 0);
    chk("rst_borrow", b8.borrow_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run8(8'h05, 8'h03, 1'b0);
    run8(8'h03, 8'h05, 1'b0);
    run8(8'hA5, 8'hA5, 1'b0);
    run8(8'h00, 8'hFF, 1'b0);
    run8(8'hFF, 8'h00, 1'b0);
    run8(8'h80, 8'h01, 1'b1);
    for (int i = 0; i < 20; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // start held high: one done every 11 cycles
    b8.a      = 8'h9C;
    b8.b      = 8'h3A;
    b8.start  = 1'b1;
    dones     = 0;
    last_done = 0;
    gap_bad   = 0;
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk); #1;
      if (b8.done) begin
        dones++;
        if (last_done != 0 && e - last_done != 11) gap_bad++;
        if (last_done == 0 && e != 10) gap_bad++;
        last_done = e;
        chk("b2b_diff", b8.diff, 8'h62);
        chk("b2b_borrow", b8.borrow_out, 0);
      end
    end
    b8.start = 1'b0;
    chk("b2b_count", dones, 3);
    chk("b2b_gap", gap_bad, 0);
    seen = 1'b0;
    for (int e = 0; e < 15 && !seen; e++) begin
      @(posedge clk); #1;
      if (b8.done) seen = 1'b1;
    end
    chk("b2b_drain", seen, 1);
    @(posedge clk); #1;

    // reset in the middle of SHIFT
    b8.a     = 8'hF0;
    b8.b     = 8'h0F;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_busy_pre", b8.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", b8.busy, 0);
    chk("mid_done", b8.done, 0);
    chk("mid_diff", b8.diff, 0);
    chk("mid_borrow", b8.borrow_out, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (b8.done) dones++;
    end
    chk("no_done_after_rst", dones, 0);
    run8(8'h37, 8'h59, 1'b0);
    run8(8'hC8, 8'h21, 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run4(4'(a), 4'(b));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
